// File: rtl/pe_typeb_stream.sv
// Streaming per-lane FP64 unit (pass / int64->double / negate / abs); optional out_count via PE_TYPEB_STATS_EN.
// Latency: LATENCY cycles for every op; stage 0 registers the input beat, the op is applied into stage 1.
// Backpressure: the whole pipe freezes while out_valid && !out_ready; in_ready is that advance term (forced high in reset).
module pe_typeb_stream #(
  parameter int LANES   = 4,
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*64-1:0]   in_data,
  input  logic [1:0]            in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*64-1:0]   out_data
`ifdef PE_TYPEB_STATS_EN
  ,
  output logic [31:0]           out_count
`endif
);

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_I2F  = 2'b01;
  localparam logic [1:0] OP_NEG  = 2'b10;

  logic                  vld_q  [LATENCY];
  logic [LANES*64-1:0]   data_q [LATENCY];
  logic [1:0]            op0_q;
  logic [LANES*64-1:0]   res_d;
  logic [63:0]           lane_w;
  logic [63:0]           lane_res;
  logic                  advance;

  // Signed int64 to binary64, round-to-nearest-even. A zero input leaves norm[63]
  // clear, which selects +0.0; the magnitude of -2^63 fits the unsigned 64-bit path.
  function automatic logic [63:0] i2f(input logic [63:0] x);
    logic        sgn;
    logic        found;
    logic [5:0]  lz;
    logic [63:0] mag;
    logic [63:0] norm;
    logic        rnd;
    logic [52:0] mant_r;
    logic [10:0] exp_v;
    sgn   = x[63];
    mag   = sgn ? (~x + 64'd1) : x;
    lz    = 6'd0;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!found && mag[i]) begin
        lz    = 6'(63 - i);
        found = 1'b1;
      end
    end
    norm   = mag << lz;
    rnd    = norm[10] & ((|norm[9:0]) | norm[11]);
    mant_r = {1'b0, norm[62:11]} + {52'd0, rnd};
    exp_v  = 11'd1086 - {5'd0, lz} + {10'd0, mant_r[52]};
    i2f    = norm[63] ? {sgn, exp_v, mant_r[51:0]} : 64'd0;
  endfunction

  assign advance   = !out_valid || out_ready;
  assign in_ready  = rst || advance;
  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

  always_comb begin
    res_d    = '0;
    lane_w   = '0;
    lane_res = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_w = data_q[0][64*k +: 64];
      case (op0_q)
        OP_PASS: lane_res = lane_w;
        OP_I2F:  lane_res = i2f(lane_w);
        OP_NEG:  lane_res = {~lane_w[63], lane_w[62:0]};
        default: lane_res = {1'b0, lane_w[62:0]};
      endcase
      res_d[64*k +: 64] = lane_res;
    end
  end

  // Bubbles shift like real beats so spacing between beats is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end
      op0_q <= OP_PASS;
    end else if (advance) begin
      vld_q[0]  <= in_valid;
      data_q[0] <= in_data;
      op0_q     <= in_op;
      vld_q[1]  <= vld_q[0];
      data_q[1] <= res_d;
      for (int i = 2; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

`ifdef PE_TYPEB_STATS_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign cnt_d     = (out_valid && out_ready) ? cnt_q + 32'd1 : cnt_q;
  assign out_count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pe_typeb_stream.sv
// Self-checking bench for pe_typeb_stream: directed vectors plus a randomized stream against a real-arithmetic model.
module tb_pe_typeb_stream;
  localparam int LANES   = 4;
  localparam int LATENCY = 4;
  localparam int W       = LANES * 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [1:0]     in_op;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
`ifdef PE_TYPEB_STATS_EN
  logic [31:0]    out_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pe_typeb_stream #(.LANES(LANES), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PE_TYPEB_STATS_EN
    ,
    .out_count (out_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_lane(input logic [1:0] op, input logic [63:0] x);
    longint s;
    real    r;
    logic [63:0] y;
    case (op)
      2'b00: y = x;
      2'b01: begin
        s = x;
        r = s;
        y = $realtobits(r);
      end
      2'b10: y = x ^ 64'h8000_0000_0000_0000;
      default: y = x & 64'h7FFF_FFFF_FFFF_FFFF;
    endcase
    return y;
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic [1:0] op, input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[64*k +: 64] = ref_lane(op, d[64*k +: 64]);
    return r;
  endfunction

  function automatic logic [63:0] rand_lane();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: v = v >> $urandom_range(0, 63);
      1: v = ~(v >> $urandom_range(0, 63)) + 64'd1;
      2: begin
        case ($urandom_range(0, 5))
          0: v = 64'h0000_0000_0000_0000;
          1: v = 64'h8000_0000_0000_0000;
          2: v = 64'h7FFF_FFFF_FFFF_FFFF;
          3: v = 64'h7FF0_0000_0000_0000;
          4: v = 64'h7FF8_0000_0000_0001;
          default: v = 64'h0020_0000_0000_0003;
        endcase
      end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < LANES; k++) b[64*k +: 64] = rand_lane();
    return b;
  endfunction

  task automatic test_reset();
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_op     = 2'b01;
    in_data   = rand_beat();
    out_ready = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    seen      = 1'b0;
    repeat (LATENCY + 4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_beat_discarded got out_valid=1 want none"); end
  endtask

  task automatic test_convert();
    logic [63:0] vin  [8];
    logic [63:0] vexp [8];
    logic [W-1:0] got;
    logic found;
    int lat;
    vin[0] = 64'd0;                    vexp[0] = 64'h0000_0000_0000_0000;
    vin[1] = 64'd1;                    vexp[1] = 64'h3FF0_0000_0000_0000;
    vin[2] = 64'hFFFF_FFFF_FFFF_FFFF;  vexp[2] = 64'hBFF0_0000_0000_0000;
    vin[3] = 64'h8000_0000_0000_0000;  vexp[3] = 64'hC3E0_0000_0000_0000;
    vin[4] = 64'h0020_0000_0000_0001;  vexp[4] = 64'h4340_0000_0000_0000;
    vin[5] = 64'h0020_0000_0000_0003;  vexp[5] = 64'h4340_0000_0000_0002;
    vin[6] = 64'h0020_0000_0000_0000;  vexp[6] = 64'h4340_0000_0000_0000;
    vin[7] = 64'h7FFF_FFFF_FFFF_FFFF;  vexp[7] = 64'h43E0_0000_0000_0000;
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < LANES; k++) in_data[64*k +: 64] = vin[v*4 + k];
      in_op     = 2'b01;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      found     = 1'b0;
      lat       = -1;
      got       = '0;
      for (int c = 0; c < 4 * LATENCY && !found; c++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          found = 1'b1;
          lat   = c;
          got   = out_data;
        end
        tick();
        in_valid = 1'b0;
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL conv%0d_timeout no out_valid within %0d cycles", v, 4 * LATENCY);
      end else begin
        checks++;
        if (lat != LATENCY) begin errors++; $display("FAIL conv%0d_latency got %0d want %0d", v, lat, LATENCY); end
        for (int k = 0; k < LANES; k++) begin
          checks++;
          if (got[64*k +: 64] !== vexp[v*4 + k]) begin
            errors++; $display("FAIL conv%0d_lane%0d got %h want %h", v, k, got[64*k +: 64], vexp[v*4 + k]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   ops  [3];
    logic [63:0]  want [3];
    logic [W-1:0] outs [3];
    int           when [3];
    int n;
    ops[0] = 2'b00; want[0] = 64'hBFF0_0000_0000_0000;
    ops[1] = 2'b10; want[1] = 64'h3FF0_0000_0000_0000;
    ops[2] = 2'b11; want[2] = 64'h3FF0_0000_0000_0000;
    n = 0;
    out_ready = 1'b1;
    in_data   = {LANES{64'hBFF0_0000_0000_0000}};
    for (int c = 0; c < LATENCY + 8; c++) begin
      if (c < 3) begin
        in_valid = 1'b1;
        in_op    = ops[c];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (n < 3) begin
          outs[n] = out_data;
          when[n] = c;
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", n);
    end else begin
      checks++;
      if (when[0] != LATENCY || when[1] != LATENCY + 1 || when[2] != LATENCY + 2) begin
        errors++; $display("FAIL b2b_timing got %0d,%0d,%0d want %0d,%0d,%0d",
                           when[0], when[1], when[2], LATENCY, LATENCY + 1, LATENCY + 2);
      end
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < LANES; k++) begin
          checks++;
          if (outs[i][64*k +: 64] !== want[i]) begin
            errors++; $display("FAIL b2b_beat%0d_lane%0d got %h want %h", i, k, outs[i][64*k +: 64], want[i]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] beats [6];
    logic [1:0]   bops  [6];
    logic [W-1:0] held;
    logic [W-1:0] exp_v;
    logic holding;
    int idx, got, stalls;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      beats[i] = rand_beat();
      bops[i]  = 2'($urandom_range(0, 3));
    end
    idx = 0; got = 0; stalls = 0; holding = 1'b0; held = '0;
    for (int c = 0; c < 80 && got < 6; c++) begin
      if (idx < 6) begin
        in_valid = 1'b1;
        in_data  = beats[idx];
        in_op    = bops[idx];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(out_valid === 1'b1 && stalls < 3);
      @(negedge clk);
      if (holding) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++; $display("FAIL bp_stable got v=%b %h want v=1 %h", out_valid, out_data, held);
        end
      end
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        stalls++;
      end
      holding = (out_valid === 1'b1) && !out_ready;
      held    = out_data;
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(ref_beat(bops[idx], beats[idx]));
        idx++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra_beat got %h want none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin errors++; $display("FAIL bp_data got %h want %h", out_data, exp_v); end
        end
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6) begin errors++; $display("FAIL bp_count got %0d want 6", got); end
    checks++;
    if (stalls != 3) begin errors++; $display("FAIL bp_stalls got %0d want 3", stalls); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_data  = rand_beat();
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b want 1", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_cleared got %b want 0", out_valid); end
    seen = 1'b0;
    repeat (3 * LATENCY) begin
      tick();
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tick();
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_ghost got out_valid=1 want none"); end
  endtask

  task automatic test_random();
    logic [W-1:0] held;
    logic [W-1:0] exp_v;
    logic holding;
    exp_q.delete();
    holding = 1'b0;
    held    = '0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_data   = rand_beat();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL rnd_in_ready got %b want %b", in_ready, !out_valid || out_ready);
      end
      if (holding) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++; $display("FAIL rnd_stable got v=%b %h want v=1 %h", out_valid, out_data, held);
        end
      end
      holding = (out_valid === 1'b1) && !out_ready;
      held    = out_data;
      if (in_valid && in_ready === 1'b1) exp_q.push_back(ref_beat(in_op, in_data));
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_beat got %h want none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin errors++; $display("FAIL rnd_data got %h want %h", out_data, exp_v); end
        end
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < LATENCY + 4; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_drain_extra got %h want none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin errors++; $display("FAIL rnd_drain_data got %h want %h", out_data, exp_v); end
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d pending want 0", exp_q.size()); end
  endtask

`ifdef PE_TYPEB_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_data  = rand_beat();
      tick();
    end
    in_valid = 1'b0;
    repeat (LATENCY + 2) tick();
    checks++;
    if (out_count !== 32'd10) begin errors++; $display("FAIL stats_count got %0d want 10", out_count); end
    force dut.cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.cnt_q;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (LATENCY + 2) tick();
    checks++;
    if (out_count !== 32'd0) begin errors++; $display("FAIL stats_wrap got %h want 0", out_count); end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_convert();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef PE_TYPEB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
